// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Width defaults, the NOP encoding and the sequencer state encoding.
package fetch_pkg;

  localparam int DEF_PC_W    = 10;
  localparam int DEF_INSTR_W = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    HALTED
  } state_e;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO holding fetched {pc, instr} pairs for decode.
// Flush wins over push and pop in the same cycle.
module fetch_buffer #(
  parameter int W = 42
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] data_i,
  output logic [1:0]   count_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] mem_q [2];
  logic         rd_q;
  logic         wr_q;
  logic [1:0]   count_q;

  assign count_o = count_q;
  assign head_o  = mem_q[rd_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ~wr_q;
      end
      if (pop_i) begin
        rd_q <= ~rd_q;
      end
      count_q <= count_q + 2'(push_i) - 2'(pop_i);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch front end: issues PCs to a 1-cycle ROM, queues the words and
// hands them to decode, with redirect flush and halt/drain control.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              PC_W     = DEF_PC_W,
  parameter int              INSTR_W  = DEF_INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [PC_W-1:0]    dec_pc,
  output logic               halted
);

  localparam int EW = PC_W + INSTR_W;

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] tag_q;
  logic            inflight_q;

  logic [1:0]      count;
  logic [EW-1:0]   head;
  logic            redir;
  logic            pop_raw;
  logic            pop;
  logic            push;
  logic [2:0]      occ;

  assign redir   = redirect_valid & (state_q != IDLE);
  assign dec_valid = (count != 2'd0);
  assign pop_raw = dec_valid & dec_ready;
  assign pop     = pop_raw & ~redir;
  assign push    = inflight_q & ~redir;

  // Slots already claimed after this cycle's pop; keep at most two.
  assign occ = {1'b0, count} + {2'b0, inflight_q} - {2'b0, pop_raw};

  assign imem_req  = (state_q == FETCH) & ~halt & (redir | (occ < 3'd2));
  assign imem_addr = redirect_valid ? redirect_pc : pc_q;

  assign dec_pc    = dec_valid ? head[EW-1 -: PC_W] : '0;
  assign dec_instr = dec_valid ? head[INSTR_W-1:0] : INSTR_W'(NOP_INSTR);
  assign halted    = (state_q == HALTED);

  fetch_buffer #(
    .W (EW)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redir),
    .data_i  ({tag_q, imem_rdata}),
    .count_o (count),
    .head_o  (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= imem_req;
      if (imem_req) begin
        pc_q  <= imem_addr + PC_W'(1);
        tag_q <= imem_addr;
      end else if (redir) begin
        pc_q <= redirect_pc;
      end
      unique case (state_q)
        IDLE:    state_q <= FETCH;
        FETCH:   if (halt) state_q <= DRAIN;
        DRAIN: begin
          if (!halt)
            state_q <= FETCH;
          else if (count == 2'd0 && !inflight_q)
            state_q <= HALTED;
        end
        HALTED:  if (!halt) state_q <= FETCH;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: streaming, stall, redirect,
// PC wrap, halt/drain/resume and mid-stream reset.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic        halt;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [9:0]  dec_pc;
  logic        halted;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [9:0] a);
    return 32'hA500_0000 | 32'(a);
  endfunction

  always @(posedge clk) imem_rdata <= rom(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic rdy, input logic rv,
                    input logic [9:0] rpc, input logic h);
    @(posedge clk);
    #1;
    dec_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt           = h;
    #1;
  endtask

  task automatic out(input string tag, input logic v,
                     input logic [9:0] pc);
    chk({tag, "_valid"}, 32'(dec_valid), 32'(v));
    if (v) begin
      chk({tag, "_pc"}, 32'(dec_pc), 32'(pc));
      chk({tag, "_instr"}, dec_instr, rom(pc));
    end else begin
      chk({tag, "_nop"}, dec_instr, NOP);
    end
  endtask

  task automatic req(input string tag, input logic r,
                     input logic [9:0] a);
    chk({tag, "_req"}, 32'(imem_req), 32'(r));
    if (r) chk({tag, "_addr"}, 32'(imem_addr), 32'(a));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    dec_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt           = 1'b0;
    #2;
    chk("rst_valid", 32'(dec_valid), 0);
    chk("rst_instr", dec_instr, NOP);
    chk("rst_pc", 32'(dec_pc), 0);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_halted", 32'(halted), 0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_req", 32'(imem_req), 0);

    for (int c = 1; c <= 6; c++) begin
      go(1, 0, 0, 0);
      req("stream", 1, 10'(c - 1));
      out("stream", c >= 3, 10'(c - 3));
    end

    for (int c = 7; c <= 11; c++) begin
      go(0, 0, 0, 0);
      req("stall", 0, 0);
      out("stall", 1, 10'd4);
    end
    for (int c = 12; c <= 15; c++) begin
      go(1, 0, 0, 0);
      req("resume", 1, 10'(c - 6));
      out("resume", 1, 10'(c - 8));
    end

    go(1, 1, 10'h200, 0);
    req("redir", 1, 10'h200);
    go(1, 0, 0, 0);
    req("redir1", 1, 10'h201);
    out("redir1", 0, 0);
    go(1, 0, 0, 0);
    out("redir2", 1, 10'h200);
    go(1, 0, 0, 0);
    out("redir3", 1, 10'h201);

    go(1, 1, 10'h3FE, 0);
    req("wrap0", 1, 10'h3FE);
    go(1, 0, 0, 0);
    req("wrap1", 1, 10'h3FF);
    out("wrap1", 0, 0);
    go(1, 0, 0, 0);
    req("wrap2", 1, 10'h000);
    out("wrap2", 1, 10'h3FE);
    go(1, 0, 0, 0);
    out("wrap3", 1, 10'h3FF);
    go(1, 0, 0, 0);
    out("wrap4", 1, 10'h000);

    go(0, 0, 0, 0);
    req("fill", 0, 0);
    go(0, 0, 0, 1);
    req("halt0", 0, 0);
    out("halt0", 1, 10'd1);
    go(1, 0, 0, 1);
    req("drain1", 0, 0);
    out("drain1", 1, 10'd1);
    chk("drain1_halted", 32'(halted), 0);
    go(1, 0, 0, 1);
    req("drain2", 0, 0);
    out("drain2", 1, 10'd2);
    go(1, 0, 0, 1);
    out("drain3", 0, 0);
    chk("drain3_halted", 32'(halted), 0);
    go(1, 0, 0, 1);
    chk("halted", 32'(halted), 1);
    req("halted", 0, 0);
    go(1, 0, 0, 0);
    chk("unhalt_halted", 32'(halted), 1);
    req("unhalt", 0, 0);
    go(1, 0, 0, 0);
    chk("restart_halted", 32'(halted), 0);
    req("restart", 1, 10'd3);
    go(1, 0, 0, 0);
    req("restart1", 1, 10'd4);
    out("restart1", 0, 0);
    go(1, 0, 0, 0);
    out("restart2", 1, 10'd3);
    go(1, 0, 0, 0);
    out("restart3", 1, 10'd4);

    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(dec_valid), 0);
    chk("mrst_instr", dec_instr, NOP);
    chk("mrst_pc", 32'(dec_pc), 0);
    chk("mrst_req", 32'(imem_req), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mrst_idle_req", 32'(imem_req), 0);
    out("mrst_idle", 0, 0);
    go(1, 0, 0, 0);
    req("mrst1", 1, 10'd0);
    out("mrst1", 0, 0);
    go(1, 0, 0, 0);
    out("mrst2", 0, 0);
    go(1, 0, 0, 0);
    out("mrst3", 1, 10'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
